// File: rtl/pe_array_issue_ctrl.sv
// Issue controller for the PE array IF stage. Buffers CP instructions in a small FIFO.
// Each cycle it presents the FIFO head, or a NOP; a per-entry repeat count re-issues the head.
module pe_array_issue_ctrl #(
  parameter int INS_WIDTH = 24,
  parameter int DEPTH = 4,
  parameter int REP_WIDTH = 4,
  parameter logic [INS_WIDTH-1:0] NOP_INS = '0
) (
  input  logic                         iClk,
  input  logic                         iReset,
  input  logic                         iCP_Valid,
  output logic                         oCP_Ready,
  input  logic [INS_WIDTH-1:0]         iCP_Instruction,
  input  logic [1:0]                   iCP_Data_Selection,
  input  logic [1:0]                   iCP_Predication,
  input  logic [REP_WIDTH-1:0]         iCP_Repeat,
  input  logic                         iStall,
  input  logic                         iFlush,
  output logic [INS_WIDTH-1:0]         oIMEM_IF_Instruction,
  output logic [1:0]                   oData_Selection,
  output logic [1:0]                   oPredication,
  output logic                         oIssue_Valid,
  output logic [$clog2(DEPTH):0]       oOccupancy,
  output logic                         oEmpty
);

  localparam int PtrWidth = $clog2(DEPTH);
  localparam int CntWidth = PtrWidth + 1;

  logic [INS_WIDTH-1:0] insMem  [DEPTH];
  logic [1:0]           dselMem [DEPTH];
  logic [1:0]           predMem [DEPTH];
  logic [REP_WIDTH-1:0] repMem  [DEPTH];

  logic [PtrWidth-1:0]  rdPtr;
  logic [PtrWidth-1:0]  wrPtr;
  logic [CntWidth-1:0]  count;
  logic [REP_WIDTH-1:0] rRep;

  logic push;
  logic issue;
  logic pop;

  // Ready looks only at the registered count, so a same-cycle pop never opens a full FIFO.
  assign oCP_Ready  = (count < CntWidth'(DEPTH));
  assign oEmpty     = (count == '0);
  assign oOccupancy = count;

  assign push  = iCP_Valid && oCP_Ready && !iFlush;
  assign issue = !oEmpty && !iStall && !iFlush;
  assign pop   = issue && (rRep == repMem[rdPtr]);

  always_ff @(posedge iClk) begin
    if (push) begin
      insMem[wrPtr]  <= iCP_Instruction;
      dselMem[wrPtr] <= iCP_Data_Selection;
      predMem[wrPtr] <= iCP_Predication;
      repMem[wrPtr]  <= iCP_Repeat;
    end
  end

  // Flush wins over push, pop and stall; rRep counts issues already made of the head.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      rRep  <= '0;
    end else if (iFlush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      rRep  <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (issue) rRep <= pop ? '0 : rRep + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    oIMEM_IF_Instruction = NOP_INS;
    oData_Selection      = 2'b00;
    oPredication         = 2'b00;
    oIssue_Valid         = 1'b0;
    if (issue) begin
      oIMEM_IF_Instruction = insMem[rdPtr];
      oData_Selection      = dselMem[rdPtr];
      oPredication         = predMem[rdPtr];
      oIssue_Valid         = 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_array_issue_ctrl.sv
// Randomized and directed bench for pe_array_issue_ctrl against a queue-based issue model.
module tb_pe_array_issue_ctrl;

  localparam int INS_WIDTH = 24;
  localparam int DEPTH = 4;
  localparam int REP_WIDTH = 4;
  localparam logic [INS_WIDTH-1:0] NOP = '0;

  typedef struct {
    logic [INS_WIDTH-1:0] ins;
    logic [1:0]           dsel;
    logic [1:0]           pred;
    logic [REP_WIDTH-1:0] rep;
    int                   left;
  } entry_t;

  logic                 iClk = 1'b0;
  logic                 iReset;
  logic                 iCP_Valid;
  logic                 oCP_Ready;
  logic [INS_WIDTH-1:0] iCP_Instruction;
  logic [1:0]           iCP_Data_Selection;
  logic [1:0]           iCP_Predication;
  logic [REP_WIDTH-1:0] iCP_Repeat;
  logic                 iStall;
  logic                 iFlush;
  logic [INS_WIDTH-1:0] oIMEM_IF_Instruction;
  logic [1:0]           oData_Selection;
  logic [1:0]           oPredication;
  logic                 oIssue_Valid;
  logic [$clog2(DEPTH):0] oOccupancy;
  logic                 oEmpty;

  int checkCount = 0;
  int errorCount = 0;

  entry_t modelQ[$];
  entry_t pendQ[$];
  logic [INS_WIDTH-1:0] issuedLog[$];
  logic [INS_WIDTH-1:0] expectLog[$];

  pe_array_issue_ctrl #(
    .INS_WIDTH(INS_WIDTH), .DEPTH(DEPTH), .REP_WIDTH(REP_WIDTH), .NOP_INS(NOP)
  ) dut (
    .iClk(iClk),
    .iReset(iReset),
    .iCP_Valid(iCP_Valid),
    .oCP_Ready(oCP_Ready),
    .iCP_Instruction(iCP_Instruction),
    .iCP_Data_Selection(iCP_Data_Selection),
    .iCP_Predication(iCP_Predication),
    .iCP_Repeat(iCP_Repeat),
    .iStall(iStall),
    .iFlush(iFlush),
    .oIMEM_IF_Instruction(oIMEM_IF_Instruction),
    .oData_Selection(oData_Selection),
    .oPredication(oPredication),
    .oIssue_Valid(oIssue_Valid),
    .oOccupancy(oOccupancy),
    .oEmpty(oEmpty)
  );

  always #5 iClk = ~iClk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic entry_t mkEntry(input logic [INS_WIDTH-1:0] ins, input logic [1:0] dsel,
                                     input logic [1:0] pred, input logic [REP_WIDTH-1:0] rep);
    entry_t e;
    e.ins = ins; e.dsel = dsel; e.pred = pred; e.rep = rep; e.left = 0;
    return e;
  endfunction

  // One cycle: drive inputs after the edge, check against the model, advance the model, cross the edge.
  task automatic applyStimulus(input logic valid, input entry_t e, input logic stall,
                               input logic flush, output logic accepted);
    logic expIssue;
    logic expReady;
    iCP_Valid = valid;
    iCP_Instruction = e.ins;
    iCP_Data_Selection = e.dsel;
    iCP_Predication = e.pred;
    iCP_Repeat = e.rep;
    iStall = stall;
    iFlush = flush;
    #2;
    expIssue = (modelQ.size() != 0) && !stall && !flush;
    expReady = (modelQ.size() < DEPTH);
    checkOutput("issue_valid", 32'(oIssue_Valid), 32'(expIssue));
    checkOutput("instruction", 32'(oIMEM_IF_Instruction), expIssue ? 32'(modelQ[0].ins) : 32'(NOP));
    checkOutput("data_sel", 32'(oData_Selection), expIssue ? 32'(modelQ[0].dsel) : 32'd0);
    checkOutput("predication", 32'(oPredication), expIssue ? 32'(modelQ[0].pred) : 32'd0);
    checkOutput("cp_ready", 32'(oCP_Ready), 32'(expReady));
    checkOutput("occupancy", 32'(oOccupancy), 32'(modelQ.size()));
    checkOutput("empty", 32'(oEmpty), 32'(modelQ.size() == 0));
    accepted = 1'b0;
    if (flush) begin
      modelQ.delete();
    end else begin
      if (expIssue) begin
        issuedLog.push_back(modelQ[0].ins);
        if (modelQ[0].left == 0) void'(modelQ.pop_front());
        else modelQ[0].left = modelQ[0].left - 1;
      end
      if (valid && expReady) begin
        e.left = int'(e.rep);
        modelQ.push_back(e);
        accepted = 1'b1;
      end
    end
    @(posedge iClk);
    #1;
  endtask

  // CP offers pendQ in order, holding each word until accepted; a bounded run until everything drains.
  task automatic runTraffic(input int gapPct, input int stallPct, input int budget);
    int cyc = 0;
    logic acc;
    logic valid;
    logic stall;
    entry_t e;
    while ((pendQ.size() != 0 || modelQ.size() != 0) && cyc < budget) begin
      valid = (pendQ.size() != 0) && ($urandom_range(99) >= gapPct);
      stall = ($urandom_range(99) < stallPct);
      e = (pendQ.size() != 0) ? pendQ[0] : mkEntry('0, 2'b0, 2'b0, '0);
      applyStimulus(valid, e, stall, 1'b0, acc);
      if (acc) void'(pendQ.pop_front());
      cyc++;
    end
    checkOutput("traffic_drained", 32'(pendQ.size() + modelQ.size()), 32'd0);
  endtask

  task automatic compareLogs(input string tag);
    checkOutput({tag, "_len"}, 32'(issuedLog.size()), 32'(expectLog.size()));
    for (int i = 0; i < issuedLog.size() && i < expectLog.size(); i++)
      checkOutput(tag, 32'(issuedLog[i]), 32'(expectLog[i]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    entry_t idle;
    entry_t a;
    entry_t b;
    logic acc;
    idle = mkEntry('0, 2'b0, 2'b0, '0);
    iReset = 1'b1;
    iCP_Valid = 1'b0; iCP_Instruction = '0; iCP_Data_Selection = '0;
    iCP_Predication = '0; iCP_Repeat = '0; iStall = 1'b0; iFlush = 1'b0;
    #7;
    checkOutput("rst_ready", 32'(oCP_Ready), 32'd1);
    checkOutput("rst_occ", 32'(oOccupancy), 32'd0);
    checkOutput("rst_empty", 32'(oEmpty), 32'd1);
    checkOutput("rst_issue", 32'(oIssue_Valid), 32'd0);
    @(posedge iClk); #1;
    iReset = 1'b0;

    // Single push with one-cycle latency, then back to NOP.
    applyStimulus(1'b1, mkEntry(24'h123456, 2'd2, 2'd1, 4'd0), 1'b0, 1'b0, acc);
    #1;
    checkOutput("single_ins", 32'(oIMEM_IF_Instruction), 32'h123456);
    checkOutput("single_valid", 32'(oIssue_Valid), 32'd1);
    #(-1 * 0);
    applyStimulus(1'b0, idle, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, idle, 1'b0, 1'b0, acc);
    checkOutput("single_empty_after", 32'(oEmpty), 32'd1);

    // Fill under stall: four accepted, the fifth held.
    issuedLog.delete(); expectLog.delete();
    for (int i = 1; i <= 5; i++) begin
      pendQ.push_back(mkEntry(INS_WIDTH'(i), 2'(i), 2'(i + 1), '0));
      expectLog.push_back(INS_WIDTH'(i));
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, pendQ[0], 1'b1, 1'b0, acc);
      if (acc) void'(pendQ.pop_front());
    end
    checkOutput("fill_occ", 32'(oOccupancy), 32'd4);
    checkOutput("fill_ready", 32'(oCP_Ready), 32'd0);
    checkOutput("fill_held", 32'(pendQ.size()), 32'd1);
    runTraffic(0, 0, 60);
    compareLogs("fill_order");

    // Repeat, plain and with a one-cycle stall after the first issue.
    for (int pass = 0; pass < 2; pass++) begin
      issuedLog.delete(); expectLog.delete();
      a = mkEntry(24'hA0A0A0 + INS_WIDTH'(pass), 2'd1, 2'd3, 4'd2);
      b = mkEntry(24'h0B0B0B, 2'd3, 2'd2, 4'd0);
      applyStimulus(1'b1, a, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, b, 1'b0, 1'b0, acc);
      if (pass == 1) begin
        applyStimulus(1'b0, idle, 1'b1, 1'b0, acc);
        checkOutput("rep_after_stall_occ", 32'(oOccupancy), 32'd2);
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, idle, 1'b0, 1'b0, acc);
      expectLog.push_back(a.ins); expectLog.push_back(a.ins);
      expectLog.push_back(a.ins); expectLog.push_back(b.ins);
      compareLogs("repeat_seq");
    end

    // Flush mid-repeat drops the pushed word and abandons A.
    issuedLog.delete();
    a = mkEntry(24'hAAAAAA, 2'd1, 2'd1, 4'd3);
    applyStimulus(1'b1, a, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, idle, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, idle, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, mkEntry(24'hCCCCCC, 2'd2, 2'd2, 4'd0), 1'b0, 1'b1, acc);
    checkOutput("flush_empty", 32'(oEmpty), 32'd1);
    checkOutput("flush_occ", 32'(oOccupancy), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, idle, 1'b0, 1'b0, acc);
    checkOutput("flush_issue_count", 32'(issuedLog.size()), 32'd2);

    // Asynchronous reset in the middle of a repeat sequence.
    applyStimulus(1'b1, mkEntry(24'h55AA55, 2'd3, 2'd3, 4'd5), 1'b0, 1'b0, acc);
    applyStimulus(1'b0, idle, 1'b0, 1'b0, acc);
    iCP_Valid = 1'b0;
    #2 iReset = 1'b1;
    #1;
    checkOutput("midrst_ins", 32'(oIMEM_IF_Instruction), 32'(NOP));
    checkOutput("midrst_issue", 32'(oIssue_Valid), 32'd0);
    checkOutput("midrst_ready", 32'(oCP_Ready), 32'd1);
    checkOutput("midrst_occ", 32'(oOccupancy), 32'd0);
    checkOutput("midrst_empty", 32'(oEmpty), 32'd1);
    modelQ.delete();
    @(posedge iClk); #1;
    iReset = 1'b0;
    applyStimulus(1'b0, idle, 1'b0, 1'b0, acc);

    // Random stream with gaps, stalls and small repeats; pointers wrap several times.
    for (int round = 0; round < 3; round++) begin
      issuedLog.delete(); expectLog.delete();
      for (int i = 0; i < 10; i++) begin
        a = mkEntry(INS_WIDTH'($urandom), 2'($urandom), 2'($urandom), REP_WIDTH'($urandom_range(2)));
        pendQ.push_back(a);
        for (int r = 0; r <= int'(a.rep); r++) expectLog.push_back(a.ins);
      end
      runTraffic(30, 25, 400);
      compareLogs("stream_order");
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
